// File: rtl/screg_bank.sv
// screg_bank: 32-bit register bank on the split register bus with WR/W1S/W1C/FIXED bit
// attributes, hardware-set status bits, registered reads and optional TMR with a scrubber.
module screg_bank #(
    parameter int unsigned               NUM_REGS       = 8,
    parameter logic [31:0]               BASE_ADDR      = 32'h0,
    parameter logic [31:0]               DEC_MASK       = 32'hFFFF_FF00,
    parameter logic [NUM_REGS-1:0][31:0] REG_INIT       = '0,
    parameter logic [NUM_REGS-1:0][31:0] REG_WR         = '0,
    parameter logic [NUM_REGS-1:0][31:0] REG_W1S        = '0,
    parameter logic [NUM_REGS-1:0][31:0] REG_W1C        = '0,
    parameter int unsigned               TMR            = 0,
    parameter int unsigned               SCRUB_INTERVAL = 1024
) (
    input  logic                     CLK,
    input  logic                     XRST,
    input  logic [31:0]              WADR,
    input  logic [3:0]               WENB,
    input  logic [31:0]              WDAT,
    output logic                     WWAT,
    output logic                     WERR,
    input  logic [31:0]              RADR,
    input  logic                     RENB,
    output logic [31:0]              RDAT,
    output logic                     RWAT,
    output logic                     RERR,
    input  logic [NUM_REGS*32-1:0]   HW_SET,
    output logic [NUM_REGS*32-1:0]   REG_Q,
    output logic                     SEU_DET,
    output logic [15:0]              SEU_CNT
);
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned LANES = (TMR != 0) ? 3 : 1;

    function automatic logic addr_hit(input logic [31:0] adr);
        logic [31:0] off;
        off = adr - BASE_ADDR;
        return ((adr & DEC_MASK) == (BASE_ADDR & DEC_MASK)) && ((off >> 2) < 32'(NUM_REGS));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] adr);
        logic [31:0] off;
        off = adr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    logic                wr_req;
    logic                wr_hit;
    logic                rd_hit;
    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic [31:0]         be_mask;
    logic [31:0]         lane_q  [LANES][NUM_REGS];
    logic [31:0]         voted   [NUM_REGS];
    logic [31:0]         reg_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] reg_load;
    logic [NUM_REGS-1:0] scan_load;
    logic [31:0]         rdat_q;
    logic                werr_q;
    logic                rerr_q;

    assign wr_req  = |WENB;
    assign wr_hit  = wr_req && addr_hit(WADR);
    assign wr_idx  = addr_idx(WADR);
    assign rd_hit  = addr_hit(RADR);
    assign rd_idx  = addr_idx(RADR);
    assign be_mask = {{8{WENB[3]}}, {8{WENB[2]}}, {8{WENB[1]}}, {8{WENB[0]}}};

    // With a single lane all three vote inputs are lane 0, so the vote is a pass-through.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            voted[r] = (lane_q[0][r] & lane_q[LANES/2][r]) |
                       (lane_q[0][r] & lane_q[LANES-1][r]) |
                       (lane_q[LANES/2][r] & lane_q[LANES-1][r]);
            REG_Q[r*32 +: 32] = voted[r];
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            reg_nxt[r]  = voted[r];
            reg_load[r] = 1'b0;
            if (wr_hit && (wr_idx == IDX_W'(r))) begin
                reg_nxt[r]  = (reg_nxt[r] & ~(be_mask & REG_WR[r])) |
                              (WDAT & be_mask & REG_WR[r]);
                reg_nxt[r]  = reg_nxt[r] | (WDAT & be_mask & REG_W1S[r]);
                reg_nxt[r]  = reg_nxt[r] & ~(WDAT & be_mask & REG_W1C[r]);
                reg_load[r] = 1'b1;
            end
            // Hardware set is applied last so it wins over a same-cycle W1C clear.
            reg_nxt[r]  = reg_nxt[r] | (HW_SET[r*32 +: 32] & REG_W1C[r]);
            reg_nxt[r]  = (reg_nxt[r] & (REG_WR[r] | REG_W1S[r] | REG_W1C[r])) |
                          (REG_INIT[r] & ~(REG_WR[r] | REG_W1S[r] | REG_W1C[r]));
            reg_load[r] = reg_load[r] | (|(HW_SET[r*32 +: 32] & REG_W1C[r])) | scan_load[r];
        end
    end

    always_ff @(posedge CLK) begin
        for (int l = 0; l < LANES; l++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (!XRST) begin
                    lane_q[l][r] <= REG_INIT[r];
                end else if (reg_load[r]) begin
                    lane_q[l][r] <= reg_nxt[r];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!XRST) begin
            rdat_q <= '0;
            rerr_q <= 1'b0;
            werr_q <= 1'b0;
        end else begin
            rdat_q <= (RENB && rd_hit) ? voted[rd_idx] : '0;
            rerr_q <= RENB && !rd_hit;
            werr_q <= wr_req && !wr_hit;
        end
    end

    assign RDAT = rdat_q;
    assign RERR = rerr_q;
    assign WERR = werr_q;
    assign WWAT = 1'b0;
    assign RWAT = 1'b0;

    if (TMR != 0) begin : g_scrub
        typedef enum logic [0:0] {StIdle, StScan} state_e;

        state_e           state_q, state_d;
        logic [31:0]      cnt_q, cnt_d;
        logic [IDX_W-1:0] idx_q, idx_d;
        logic             mismatch;
        logic             seu_det_q;
        logic [15:0]      seu_cnt_q;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            idx_d     = idx_q;
            scan_load = '0;
            mismatch  = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cnt_q == '0) begin
                        state_d = StScan;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                StScan: begin
                    // Reloading the voted value is harmless when the lanes already agree.
                    scan_load[idx_q] = 1'b1;
                    mismatch = (lane_q[0][idx_q] != lane_q[1][idx_q]) ||
                               (lane_q[1][idx_q] != lane_q[2][idx_q]);
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        state_d = StIdle;
                        cnt_d   = 32'(SCRUB_INTERVAL - 1);
                    end
                end
            endcase
        end

        always_ff @(posedge CLK) begin
            if (!XRST) begin
                state_q   <= StIdle;
                cnt_q     <= 32'(SCRUB_INTERVAL - 1);
                idx_q     <= '0;
                seu_det_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                idx_q     <= idx_d;
                seu_det_q <= mismatch;
            end
        end

        always_ff @(posedge CLK) begin
            if (!XRST) begin
                seu_cnt_q <= '0;
            end else if (mismatch && (seu_cnt_q != 16'hFFFF)) begin
                seu_cnt_q <= seu_cnt_q + 16'd1;
            end
        end

        assign SEU_DET = seu_det_q;
        assign SEU_CNT = seu_cnt_q;
    end else begin : g_no_scrub
        assign scan_load = '0;
        assign SEU_DET   = 1'b0;
        assign SEU_CNT   = '0;
    end

endmodule

// File: tb/tb_screg_bank.sv
// Directed bench for screg_bank: read results are queued when a read is issued and checked
// against RDAT/RERR one cycle later; WERR and SEU_DET are checked on every cycle.
module tb_screg_bank;
    localparam int unsigned NREG     = 4;
    localparam int unsigned INTERVAL = 8;
    localparam int          PERIOD   = INTERVAL + NREG;
    localparam int          DET      = INTERVAL + 1;

    logic                 clk = 1'b0;
    logic                 xrst;
    logic [31:0]          wadr;
    logic [3:0]           wenb;
    logic [31:0]          wdat;
    logic                 wwat;
    logic                 werr;
    logic [31:0]          radr;
    logic                 renb;
    logic [31:0]          rdat;
    logic                 rwat;
    logic                 rerr;
    logic [NREG*32-1:0]   hw_set;
    logic [NREG*32-1:0]   reg_q;
    logic                 seu_det;
    logic [15:0]          seu_cnt;

    always #5 clk = ~clk;

    screg_bank #(
        .NUM_REGS      (NREG),
        .BASE_ADDR     (32'h0),
        .DEC_MASK      (32'hFFFF_FF00),
        .REG_INIT      ({32'hDEAD_BEEF, 32'hA5A5_0000, 32'h0000_0000, 32'h0000_00F0}),
        .REG_WR        ({32'h0000_0000, 32'h0000_FFFF, 32'hFF00_0000, 32'hFFFF_FFFF}),
        .REG_W1S       ({32'h0000_0000, 32'h0000_0000, 32'h0000_00FF, 32'h0000_0000}),
        .REG_W1C       ({32'h0000_0000, 32'h0000_0000, 32'h0000_FF00, 32'h0000_0000}),
        .TMR           (1),
        .SCRUB_INTERVAL(INTERVAL)
    ) dut (
        .CLK    (clk),
        .XRST   (xrst),
        .WADR   (wadr),
        .WENB   (wenb),
        .WDAT   (wdat),
        .WWAT   (wwat),
        .WERR   (werr),
        .RADR   (radr),
        .RENB   (renb),
        .RDAT   (rdat),
        .RWAT   (rwat),
        .RERR   (rerr),
        .HW_SET (hw_set),
        .REG_Q  (reg_q),
        .SEU_DET(seu_det),
        .SEU_CNT(seu_cnt)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    rd_exp_t sb [$];
    int      n_tests  = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    int      seu_at   = -1;
    logic    werr_exp = 1'b0;
    int      c0;
    int      c1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input int i, input logic [31:0] exp, input string tag);
        chk(tag, reg_q[i*32 +: 32], exp);
    endtask

    task automatic step();
        rd_exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("rdat@%h", e.adr), rdat, e.data);
            chk($sformatf("rerr@%h", e.adr), {31'b0, rerr}, {31'b0, e.err});
        end else begin
            chk("rdat_idle", rdat, 32'h0);
            chk("rerr_idle", {31'b0, rerr}, 32'h0);
        end
        chk("werr", {31'b0, werr}, {31'b0, werr_exp});
        werr_exp = 1'b0;
        chk($sformatf("seu_det@%0d", cyc), {31'b0, seu_det}, (cyc == seu_at) ? 32'h1 : 32'h0);
        chk("wait", {30'b0, wwat, rwat}, 32'h0);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp_data, input logic exp_err);
        rd_exp_t e;
        e.adr  = adr;
        e.data = exp_data;
        e.err  = exp_err;
        radr   = adr;
        renb   = 1'b1;
        sb.push_back(e);
        step();
        renb = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [3:0] be, input logic [31:0] dat,
                      input logic exp_err);
        wadr     = adr;
        wenb     = be;
        wdat     = dat;
        werr_exp = exp_err;
        step();
        wenb = 4'h0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        xrst = 1'b0;
        step();
        step();
        xrst = 1'b1;
    endtask

    task automatic inject();
        dut.lane_q[1][0] = dut.lane_q[1][0] ^ 32'h0000_0008;
    endtask

    initial begin
        xrst   = 1'b0;
        wadr   = '0;
        wenb   = '0;
        wdat   = '0;
        radr   = '0;
        renb   = 1'b0;
        hw_set = '0;
        do_reset();

        chk_reg(0, 32'h0000_00F0, "init_r0");
        chk_reg(1, 32'h0000_0000, "init_r1");
        chk_reg(2, 32'hA5A5_0000, "init_r2");
        chk_reg(3, 32'hDEAD_BEEF, "init_r3");
        chk("seu_cnt_init", {16'h0, seu_cnt}, 32'h0);

        rd(32'h08, 32'hA5A5_0000, 1'b0);
        wr(32'h08, 4'hF, 32'hFFFF_1234, 1'b0);
        chk_reg(2, 32'hA5A5_1234, "wr_r2");
        rd(32'h08, 32'hA5A5_1234, 1'b0);
        wr(32'h08, 4'h1, 32'h0000_00FF, 1'b0);
        chk_reg(2, 32'hA5A5_12FF, "be_r2");

        hw_set[47:40] = 8'hFF;
        step();
        hw_set = '0;
        chk_reg(1, 32'h0000_FF00, "hwset_r1");
        wr(32'h04, 4'h3, 32'h0000_0F0F, 1'b0);
        chk_reg(1, 32'h0000_F00F, "w1s_w1c_r1");
        hw_set[47:40] = 8'hFF;
        step();
        hw_set = '0;
        chk_reg(1, 32'h0000_FF0F, "hwset2_r1");
        wr(32'h04, 4'h1, 32'h0000_F0F0, 1'b0);
        chk_reg(1, 32'h0000_FFFF, "be1_r1");
        wr(32'h04, 4'h8, 32'hAB00_0000, 1'b0);
        chk_reg(1, 32'hAB00_FFFF, "wr_byte3_r1");
        wr(32'h04, 4'hF, 32'h0000_0100, 1'b0);
        chk_reg(1, 32'h0000_FEFF, "w1c_bit8_r1");
        hw_set[40] = 1'b1;
        hw_set[48] = 1'b1;
        wr(32'h04, 4'h2, 32'h0000_0100, 1'b0);
        hw_set = '0;
        chk_reg(1, 32'h0000_FFFF, "hwset_wins_r1");
        rd(32'h04, 32'h0000_FFFF, 1'b0);

        wr(32'h0C, 4'hF, 32'hFFFF_FFFF, 1'b0);
        chk_reg(3, 32'hDEAD_BEEF, "fixed_r3");

        wr(32'h10, 4'hF, 32'hFFFF_FFFF, 1'b1);
        chk_reg(0, 32'h0000_00F0, "unmap_r0");
        chk_reg(1, 32'h0000_FFFF, "unmap_r1");
        chk_reg(2, 32'hA5A5_12FF, "unmap_r2");
        chk_reg(3, 32'hDEAD_BEEF, "unmap_r3");
        wr(32'h0001_0008, 4'hF, 32'h0000_0000, 1'b1);
        chk_reg(2, 32'hA5A5_12FF, "unsel_r2");
        rd(32'h0001_0000, 32'h0, 1'b1);
        rd(32'h10, 32'h0, 1'b1);
        rd(32'h0B, 32'hA5A5_12FF, 1'b0);

        // Same-cycle write and read of reg0 returns the old value.
        wadr = 32'h00;
        wenb = 4'hF;
        wdat = 32'h1234_5678;
        rd(32'h00, 32'h0000_00F0, 1'b0);
        wenb = 4'h0;
        chk_reg(0, 32'h1234_5678, "collide_r0");

        rd(32'h00, 32'h1234_5678, 1'b0);
        rd(32'h08, 32'hA5A5_12FF, 1'b0);
        rd(32'h14, 32'h0, 1'b1);
        rd(32'h0C, 32'hDEAD_BEEF, 1'b0);
        step();

        // Scrubber: first reg0 scan lands INTERVAL cycles after reset release.
        do_reset();
        c0 = cyc;
        inject();
        seu_at = c0 + DET;
        rd(32'h00, 32'h0000_00F0, 1'b0);
        run_to(c0 + DET);
        chk("seu_cnt_1", {16'h0, seu_cnt}, 32'h1);
        chk("lane1_scrubbed", dut.lane_q[1][0], 32'h0000_00F0);
        run_to(c0 + DET + PERIOD);
        chk("seu_cnt_hold", {16'h0, seu_cnt}, 32'h1);

        dut.g_scrub.seu_cnt_q = 16'hFFFE;
        inject();
        seu_at = c0 + DET + 2 * PERIOD;
        run_to(seu_at);
        chk("seu_cnt_ffff", {16'h0, seu_cnt}, 32'h0000_FFFF);
        inject();
        seu_at = c0 + DET + 3 * PERIOD;
        run_to(seu_at);
        chk("seu_cnt_sat", {16'h0, seu_cnt}, 32'h0000_FFFF);

        // Two cycles after the reg0 scan the pass is at idx 2; reset aborts it.
        run_to(c0 + DET + 3 * PERIOD + 1);
        xrst = 1'b0;
        step();
        chk("seu_cnt_rst", {16'h0, seu_cnt}, 32'h0);
        chk_reg(0, 32'h0000_00F0, "rst_r0");
        xrst = 1'b1;
        c1 = cyc;
        inject();
        seu_at = c1 + DET;
        run_to(c1 + DET + 2);
        chk("seu_cnt_after_rst", {16'h0, seu_cnt}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
